// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers of the MIPS32 core.
// Provides the stage-occupancy enum, ID/EX default widths and control-bundle field layout.
package pipe_pkg;

  // Encoding mirrors {skid_valid, main_valid}; 2'b10 is the unreachable combination
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } stage_state_e;

  // ID/EX default widths
  localparam int unsigned IDEX_CTRL_W  = 9;
  localparam int unsigned IDEX_DATA_W  = 32;
  localparam int unsigned IDEX_NUM_OPS = 5;

  // Control-bundle bit positions (ID/EX layout)
  localparam int unsigned CB_BRANCH    = 0;
  localparam int unsigned CB_ALU_OP    = 1;  // occupies [2:1]
  localparam int unsigned CB_ALU_OP_W  = 2;
  localparam int unsigned CB_MEMTO_REG = 3;
  localparam int unsigned CB_MEM_WRITE = 4;
  localparam int unsigned CB_MEM_READ  = 5;
  localparam int unsigned CB_ALU_SRC   = 6;
  localparam int unsigned CB_REG_WRITE = 7;
  localparam int unsigned CB_REG_DST   = 8;

  // Structured view of the ID/EX control bundle, same bit layout as the CB_* indices
  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic [1:0] alu_op;
    logic       branch;
  } idex_ctrl_t;

  // Decode the occupancy state from the two valid bits
  function automatic stage_state_e stage_state(input logic main_v, input logic skid_v);
    if (skid_v)      return ST_SKID;
    else if (main_v) return ST_FULL;
    else             return ST_EMPTY;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: clk, rst (async active-low), clr, inc, count[W-1:0] (registered).
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up to all-ones and hold there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer (main + skid).
// Carries a control bundle and NUM_OPS operands; full throughput with in_ready
// derived only from registered state (and flush). Adds synchronous flush,
// bubble control value when idle, and a saturating back-pressure cycle counter.
// Ports:
//   clk, rst (async active-low)
//   in_valid/in_ready/in_ctrl/in_data   upstream handshake and payload
//   flush                               kill all held beats
//   out_valid/out_ready/out_ctrl/out_data downstream handshake and payload
//   stat_clr, stall_cnt                 clear / count of out_valid && !out_ready cycles
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = IDEX_DATA_W,
  parameter int unsigned       NUM_OPS     = IDEX_NUM_OPS,
  parameter int unsigned       CTRL_W      = IDEX_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_OPS*DATA_W-1:0] in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NUM_OPS*DATA_W-1:0] out_data,
  input  logic                      stat_clr,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned PAY_W = NUM_OPS * DATA_W;

  logic              main_valid, main_valid_n;
  logic              skid_valid, skid_valid_n;
  logic [CTRL_W-1:0] main_ctrl,  main_ctrl_n;
  logic [PAY_W-1:0]  main_data,  main_data_n;
  logic [CTRL_W-1:0] skid_ctrl,  skid_ctrl_n;
  logic [PAY_W-1:0]  skid_data,  skid_data_n;

  stage_state_e state;
  logic         acc;
  logic         tak;

  // Handshake view; flush blocks both transfers in its cycle
  assign in_ready  = !skid_valid && !flush;
  assign out_valid = main_valid && !flush;
  assign out_ctrl  = out_valid ? main_ctrl : CTRL_BUBBLE;
  assign out_data  = main_data;

  assign acc   = in_valid && in_ready;
  assign tak   = out_valid && out_ready;
  assign state = stage_state(main_valid, skid_valid);

  // State and payload registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      main_ctrl  <= main_ctrl_n;
      main_data  <= main_data_n;
      skid_ctrl  <= skid_ctrl_n;
      skid_data  <= skid_data_n;
    end
  end

  // Next-state: skid entry is always older than the input, so it drains first
  always_comb begin
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    main_ctrl_n  = main_ctrl;
    main_data_n  = main_data;
    skid_ctrl_n  = skid_ctrl;
    skid_data_n  = skid_data;

    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_valid_n = 1'b1;
            main_ctrl_n  = in_ctrl;
            main_data_n  = in_data;
          end
        end
        ST_FULL: begin
          if (acc && tak) begin
            main_ctrl_n = in_ctrl;
            main_data_n = in_data;
          end else if (tak) begin
            main_valid_n = 1'b0;
          end else if (acc) begin
            skid_valid_n = 1'b1;
            skid_ctrl_n  = in_ctrl;
            skid_data_n  = in_data;
          end
        end
        ST_SKID: begin
          if (tak) begin
            skid_valid_n = 1'b0;
            main_ctrl_n  = skid_ctrl;
            main_data_n  = skid_data;
          end
        end
        default: begin
          main_valid_n = 1'b0;
          skid_valid_n = 1'b0;
        end
      endcase
    end
  end

  // Back-pressure statistics
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  // Skid entry can only be occupied behind a valid main entry
  a_no_orphan_skid: assert property (@(posedge clk) disable iff (!rst) (main_valid || !skid_valid));

endmodule
